// File: rtl/register_bank_bist_pkg.sv
// Shared types and pattern helper for the register bank built-in self-test.
package register_bank_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDone
  } state_e;

  localparam logic [63:0] DEFAULT_PATTERN_STEP = 64'h11;

  // Full 64-bit product; callers truncate to their data width.
  function automatic logic [63:0] expected_value(input logic [63:0] idx,
                                                 input logic [63:0] step);
    return idx * step;
  endfunction

endpackage

// File: rtl/register_bank_bist.sv
// BIST initiator: fills a register bank with an index-derived pattern, then reads it back
// two registers at a time and reports pass or the first mismatch.
module register_bank_bist
  import register_bank_bist_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter logic [63:0] PATTERN_STEP = DEFAULT_PATTERN_STEP,
  parameter int unsigned READ_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              we5,
  output logic [ADDR_W-1:0] wa5,
  output logic [DATA_W-1:0] wd32,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2
);

  if ((NUM_REGS % 2) != 0 || NUM_REGS == 0) begin : g_bad_num_regs
    $fatal(1, "register_bank_bist: NUM_REGS must be even and non-zero");
  end
  if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
    $fatal(1, "register_bank_bist: ADDR_W too small for NUM_REGS");
  end
  if (READ_LAT < 1) begin : g_bad_read_lat
    $fatal(1, "register_bank_bist: READ_LAT must be >= 1");
  end
  if (DATA_W > 64 || DATA_W == 0) begin : g_bad_data_w
    $fatal(1, "register_bank_bist: DATA_W must be 1..64");
  end

  localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WAIT_W-1:0] WaitReload = WAIT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_e              r_state, w_state_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_pass, w_pass_d;
  logic [ADDR_W-1:0]   r_fail_addr, w_fail_addr_d;
  logic [DATA_W-1:0]   r_fail_exp, w_fail_exp_d;
  logic [DATA_W-1:0]   r_fail_got, w_fail_got_d;
  logic                r_we, w_we_d;
  logic [ADDR_W-1:0]   r_wa, w_wa_d;
  logic [DATA_W-1:0]   r_wd, w_wd_d;
  logic [ADDR_W-1:0]   r_ra1, w_ra1_d;
  logic [ADDR_W-1:0]   r_ra2, w_ra2_d;
  logic [WAIT_W-1:0]   r_wait, w_wait_d;

  logic [ADDR_W-1:0]   w_wa_next;
  logic [DATA_W-1:0]   w_wd_next;
  logic [DATA_W-1:0]   w_exp1;
  logic [DATA_W-1:0]   w_exp2;

  assign w_wa_next = r_wa + ADDR_W'(1);
  assign w_wd_next = DATA_W'(expected_value(64'(w_wa_next), PATTERN_STEP));
  assign w_exp1    = DATA_W'(expected_value(64'(r_ra1), PATTERN_STEP));
  assign w_exp2    = DATA_W'(expected_value(64'(r_ra2), PATTERN_STEP));

  always_comb begin
    w_state_d     = r_state;
    w_busy_d      = r_busy;
    w_done_d      = r_done;
    w_pass_d      = r_pass;
    w_fail_addr_d = r_fail_addr;
    w_fail_exp_d  = r_fail_exp;
    w_fail_got_d  = r_fail_got;
    w_we_d        = r_we;
    w_wa_d        = r_wa;
    w_wd_d        = r_wd;
    w_ra1_d       = r_ra1;
    w_ra2_d       = r_ra2;
    w_wait_d      = r_wait;

    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_d     = StWrite;
          w_busy_d      = 1'b1;
          w_done_d      = 1'b0;
          w_pass_d      = 1'b0;
          w_fail_addr_d = '0;
          w_fail_exp_d  = '0;
          w_fail_got_d  = '0;
          w_we_d        = 1'b1;
          w_wa_d        = '0;
          w_wd_d        = '0;
        end
      end
      StWrite: begin
        if (r_wa == LastAddr) begin
          w_we_d    = 1'b0;
          w_state_d = StRead;
          w_ra1_d   = '0;
          w_ra2_d   = ADDR_W'(1);
          w_wait_d  = WaitReload;
        end else begin
          w_wa_d = w_wa_next;
          w_wd_d = w_wd_next;
        end
      end
      StRead: begin
        if (r_wait != '0) begin
          w_wait_d = r_wait - WAIT_W'(1);
        end else if (rd1 != w_exp1) begin
          // rd1 is checked first so the lower (even) address wins within a pair.
          w_state_d     = StDone;
          w_busy_d      = 1'b0;
          w_done_d      = 1'b1;
          w_pass_d      = 1'b0;
          w_fail_addr_d = r_ra1;
          w_fail_exp_d  = w_exp1;
          w_fail_got_d  = rd1;
        end else if (rd2 != w_exp2) begin
          w_state_d     = StDone;
          w_busy_d      = 1'b0;
          w_done_d      = 1'b1;
          w_pass_d      = 1'b0;
          w_fail_addr_d = r_ra2;
          w_fail_exp_d  = w_exp2;
          w_fail_got_d  = rd2;
        end else if (r_ra2 == LastAddr) begin
          w_state_d = StDone;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_pass_d  = 1'b1;
        end else begin
          w_ra1_d  = r_ra1 + ADDR_W'(2);
          w_ra2_d  = r_ra2 + ADDR_W'(2);
          w_wait_d = WaitReload;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_ra1       <= '0;
      r_ra2       <= '0;
      r_wait      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_pass      <= w_pass_d;
      r_fail_addr <= w_fail_addr_d;
      r_fail_exp  <= w_fail_exp_d;
      r_fail_got  <= w_fail_got_d;
      r_we        <= w_we_d;
      r_wa        <= w_wa_d;
      r_wd        <= w_wd_d;
      r_ra1       <= w_ra1_d;
      r_ra2       <= w_ra2_d;
      r_wait      <= w_wait_d;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_got  = r_fail_got;
  assign we5       = r_we;
  assign wa5       = r_wa;
  assign wd32      = r_wd;
  assign ra1       = r_ra1;
  assign ra2       = r_ra2;

endmodule

// File: tb/tb_register_bank_bist.sv
// Directed bench: combinational-read bank with injectable faults, plus a registered-read bank.
module tb_register_bank_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;
  int   fault_mode;  // 0 none, 1 reg7 stuck at 0, 2 regs 4/5 read 0xDEAD

  logic        busy, done, pass, we5;
  logic [4:0]  fail_addr, wa5, ra1, ra2;
  logic [31:0] fail_exp, fail_got, wd32, rd1, rd2;

  logic        busy2, done2, pass2, we5_2;
  logic [4:0]  fail_addr2, wa5_2, ra1_2, ra2_2;
  logic [31:0] fail_exp2, fail_got2, wd32_2, rd1_2, rd2_2;

  logic [31:0] mem [32];
  logic [31:0] mem2 [32];

  int n_cmp = 0;
  int n_fail = 0;

  register_bank_bist #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .PATTERN_STEP(64'h11), .READ_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .we5(we5), .wa5(wa5), .wd32(wd32), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  register_bank_bist #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .PATTERN_STEP(64'h11), .READ_LAT(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_got(fail_got2),
    .we5(we5_2), .wa5(wa5_2), .wd32(wd32_2), .ra1(ra1_2), .ra2(ra2_2),
    .rd1(rd1_2), .rd2(rd2_2)
  );

  always @(posedge clk) if (we5) mem[wa5] <= wd32;

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (fault_mode == 1 && ra1 == 5'd7) rd1 = 32'h0;
    if (fault_mode == 1 && ra2 == 5'd7) rd2 = 32'h0;
    if (fault_mode == 2 && (ra1 == 5'd4 || ra1 == 5'd5)) rd1 = 32'hDEAD;
    if (fault_mode == 2 && (ra2 == 5'd4 || ra2 == 5'd5)) rd2 = 32'hDEAD;
  end

  always @(posedge clk) begin
    if (we5_2) mem2[wa5_2] <= wd32_2;
    rd1_2 <= mem2[ra1_2];
    rd2_2 <= mem2[ra2_2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after the accepting edge E0.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    fault_mode = 0;
    step(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_pass", 64'({done, pass}), 64'd0);
    check("rst_fail", 64'({fail_addr, fail_exp, fail_got}), 64'd0);
    check("rst_write_port", 64'({we5, wa5, wd32}), 64'd0);
    check("rst_read_addr", 64'({ra1, ra2}), 64'd0);
    check("rst_dut2_busy_done", 64'({busy2, done2}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Clean bank: full write sweep, then pass at E48.
    pulse_start();
    check("e0_we5", 64'(we5), 64'd1);
    check("e0_wa_wd", 64'({wa5, wd32}), 64'd0);
    check("e0_busy", 64'(busy), 64'd1);
    for (int i = 1; i < 32; i++) begin
      step(1);
      check("wr_we5", 64'(we5), 64'd1);
      check("wr_wa5", 64'(wa5), 64'(i));
      check("wr_wd32", 64'(wd32), 64'(i * 17));
    end
    check("wr_last_wd32", 64'(wd32), 64'h20F);
    step(1);  // E32
    check("e32_we5", 64'(we5), 64'd0);
    check("e32_ra", 64'({ra1, ra2}), 64'({5'd0, 5'd1}));
    check("e32_busy", 64'(busy), 64'd1);
    step(1);  // E33
    check("e33_ra", 64'({ra1, ra2}), 64'({5'd2, 5'd3}));
    step(14);  // E47
    check("e47_done", 64'(done), 64'd0);
    step(1);  // E48
    check("e48_done", 64'(done), 64'd1);
    check("e48_pass", 64'(pass), 64'd1);
    check("e48_busy", 64'(busy), 64'd0);
    check("e48_ra_hold", 64'({ra1, ra2}), 64'({5'd30, 5'd31}));
    step(3);
    check("done_held", 64'({done, pass, ra1}), 64'({1'b1, 1'b1, 5'd30}));

    // Register 7 stuck at zero; restart from DONE clears the previous result.
    fault_mode = 1;
    pulse_start();
    check("restart_clears", 64'({done, pass, busy}), 64'({1'b0, 1'b0, 1'b1}));
    step(35);  // E35
    check("s7_e35_done", 64'(done), 64'd0);
    step(1);   // E36
    check("s7_done_pass", 64'({done, pass, busy}), 64'({1'b1, 1'b0, 1'b0}));
    check("s7_fail_addr", 64'(fail_addr), 64'd7);
    check("s7_fail_exp", 64'(fail_exp), 64'h77);
    check("s7_fail_got", 64'(fail_got), 64'h0);

    // Registers 4 and 5 corrupted: the even register is reported.
    fault_mode = 2;
    pulse_start();
    check("c45_cleared_fail", 64'({fail_addr, fail_exp}), 64'd0);
    step(34);  // E34
    check("c45_e34_done", 64'(done), 64'd0);
    step(1);   // E35
    check("c45_done_pass", 64'({done, pass}), 64'({1'b1, 1'b0}));
    check("c45_fail_addr", 64'(fail_addr), 64'd4);
    check("c45_fail_exp", 64'(fail_exp), 64'h44);
    check("c45_fail_got", 64'(fail_got), 64'hDEAD);

    // Start re-pulsed at E20 while busy is ignored.
    fault_mode = 0;
    pulse_start();
    step(19);  // E19
    start = 1'b1;
    step(1);   // E20
    start = 1'b0;
    check("rp_e20_wa5", 64'(wa5), 64'd20);
    check("rp_e20_we_busy", 64'({we5, busy}), 64'({1'b1, 1'b1}));
    step(1);   // E21
    check("rp_e21_wa5", 64'(wa5), 64'd21);
    step(26);  // E47
    check("rp_e47_done", 64'(done), 64'd0);
    step(1);   // E48
    check("rp_e48_done_pass", 64'({done, pass}), 64'({1'b1, 1'b1}));

    // Reset asserted at E10 in the middle of the write phase.
    pulse_start();
    step(9);   // E9
    check("mr_e9_we5", 64'(we5), 64'd1);
    rst = 1'b0;
    step(1);   // E10
    rst = 1'b1;
    check("mr_we5", 64'(we5), 64'd0);
    check("mr_busy_done_pass", 64'({busy, done, pass}), 64'd0);
    check("mr_ports", 64'({wa5, wd32, ra1, ra2}), 64'd0);
    pulse_start();
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      step(1);
      k++;
    end
    check("mr_rerun_done", 64'(done), 64'd1);
    check("mr_rerun_latency", 64'(k), 64'd48);
    check("mr_rerun_pass", 64'(pass), 64'd1);

    // Two-cycle read latency against the registered-read bank.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("l2_e0_we_busy", 64'({we5_2, busy2}), 64'({1'b1, 1'b1}));
    step(33);  // E33
    check("l2_e33_ra_hold", 64'({ra1_2, ra2_2}), 64'({5'd0, 5'd1}));
    step(1);   // E34
    check("l2_e34_ra", 64'({ra1_2, ra2_2}), 64'({5'd2, 5'd3}));
    step(29);  // E63
    check("l2_e63_done", 64'(done2), 64'd0);
    step(1);   // E64
    check("l2_e64_done_pass", 64'({done2, pass2, busy2}), 64'({1'b1, 1'b1, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
